// File: rtl/ras_ctrl.sv
// Return-address stack sequencer: serialises dual-slot call/ret ops, tracks committed top/depth, rolls back on flush.
// Optional RAS_CTRL_STAT_EN adds flush/stall/underflow event counters.
module ras_ctrl #(
   parameter int          ENTRY_WIDTH = 3,
   parameter logic [31:0] RET_OFFSET  = 32'd8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             f_valid,
   input  logic [1:0]             f_call,
   input  logic [1:0]             f_ret,
   input  logic [31:0]            f_pc0,
   input  logic [31:0]            f_pc1,
   input  logic [1:0]             c_call,
   input  logic [1:0]             c_ret,
   input  logic                   flush,
   output logic                   f_stall,
   output logic                   push,
   output logic                   pop,
   output logic [31:0]            pc,
   output logic                   top_reset,
   output logic [ENTRY_WIDTH-1:0] top_commit,
   output logic [ENTRY_WIDTH:0]   spec_depth,
`ifdef RAS_CTRL_STAT_EN
   output logic [31:0]            stat_flush,
   output logic [31:0]            stat_stall,
   output logic [31:0]            stat_underflow,
`endif
   output logic                   underflow
);

   localparam logic [ENTRY_WIDTH:0] DMAX = {1'b1, {ENTRY_WIDTH{1'b0}}};

   typedef enum logic [1:0] {IDLE, PEND, RECOV} state_t;

   state_t                 state, state_nx;
   logic                   pend_call, pend_ret;
   logic [31:0]            pend_pc;
   logic                   ld_pend;
   logic                   op_call, op_ret;
   logic [31:0]            op_pc;
   logic                   op0, op1;
   logic [ENTRY_WIDTH-1:0] ctop, ct_nx;
   logic [ENTRY_WIDTH:0]   cdepth, cd_nx;

   assign op0 = f_valid[0] & (f_call[0] | f_ret[0]);
   assign op1 = f_valid[1] & (f_call[1] | f_ret[1]);

   // Net commit effect, slot 0 first so saturation/floor apply in order.
   always_comb begin
      ct_nx = ctop;
      cd_nx = cdepth;
      for (int i = 0; i < 2; i++) begin
         if (c_call[i] && !c_ret[i]) begin
            ct_nx = ct_nx + ENTRY_WIDTH'(1);
            if (cd_nx != DMAX) cd_nx = cd_nx + (ENTRY_WIDTH+1)'(1);
         end else if (c_ret[i] && !c_call[i]) begin
            ct_nx = ct_nx - ENTRY_WIDTH'(1);
            if (cd_nx != '0) cd_nx = cd_nx - (ENTRY_WIDTH+1)'(1);
         end
      end
   end

   always_comb begin
      state_nx  = state;
      f_stall   = 1'b0;
      op_call   = 1'b0;
      op_ret    = 1'b0;
      op_pc     = '0;
      ld_pend   = 1'b0;
      top_reset = 1'b0;
      case (state)
         IDLE: begin
            if (op0) begin
               op_call = f_call[0];
               op_ret  = f_ret[0];
               op_pc   = f_pc0;
               if (op1) begin
                  f_stall  = 1'b1;
                  ld_pend  = 1'b1;
                  state_nx = PEND;
               end
            end else if (op1) begin
               op_call = f_call[1];
               op_ret  = f_ret[1];
               op_pc   = f_pc1;
            end
         end
         PEND: begin
            op_call  = pend_call;
            op_ret   = pend_ret;
            op_pc    = pend_pc;
            state_nx = IDLE;
         end
         RECOV: begin
            f_stall  = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (flush) begin
         op_call   = 1'b0;
         op_ret    = 1'b0;
         ld_pend   = 1'b0;
         top_reset = 1'b1;
         f_stall   = (state == RECOV);
         state_nx  = RECOV;
      end
      if (reset) begin
         f_stall   = 1'b0;
         op_call   = 1'b0;
         op_ret    = 1'b0;
         top_reset = 1'b0;
         ld_pend   = 1'b0;
      end
   end

   // A lone pop on an empty stack is dropped; push+pop (replace) is always legal.
   assign underflow  = op_ret & ~op_call & (spec_depth == '0);
   assign push       = op_call;
   assign pop        = op_ret & ~underflow;
   assign pc         = push ? (op_pc + RET_OFFSET) : 32'd0;
   assign top_commit = reset ? '0 : ct_nx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         pend_call  <= 1'b0;
         pend_ret   <= 1'b0;
         pend_pc    <= '0;
         ctop       <= '0;
         cdepth     <= '0;
         spec_depth <= '0;
      end else begin
         state  <= state_nx;
         ctop   <= ct_nx;
         cdepth <= cd_nx;
         if (ld_pend) begin
            pend_call <= f_call[1];
            pend_ret  <= f_ret[1];
            pend_pc   <= f_pc1;
         end
         if (flush)
            spec_depth <= cd_nx;
         else if (push && !pop && spec_depth != DMAX)
            spec_depth <= spec_depth + (ENTRY_WIDTH+1)'(1);
         else if (pop && !push)
            spec_depth <= spec_depth - (ENTRY_WIDTH+1)'(1);
      end
   end

`ifdef RAS_CTRL_STAT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_flush     <= '0;
         stat_stall     <= '0;
         stat_underflow <= '0;
      end else begin
         if (flush)     stat_flush     <= stat_flush + 32'd1;
         if (f_stall)   stat_stall     <= stat_stall + 32'd1;
         if (underflow) stat_underflow <= stat_underflow + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Self-checking bench for ras_ctrl: directed vector table, wrap sequence, and random run against a queue-based model.
module tb_ras_ctrl;

   localparam int EW   = 3;
   localparam int DMAX = 1 << EW;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    f_valid, f_call, f_ret, c_call, c_ret;
   logic [31:0]   f_pc0, f_pc1;
   logic          flush;
   logic          f_stall, push, pop, top_reset, underflow;
   logic [31:0]   pc;
   logic [EW-1:0] top_commit;
   logic [EW:0]   spec_depth;
`ifdef RAS_CTRL_STAT_EN
   logic [31:0]   stat_flush, stat_stall, stat_underflow;
`endif

   ras_ctrl #(.ENTRY_WIDTH(EW), .RET_OFFSET(32'd8)) dut (
      .clk(clk), .reset(reset), .f_valid(f_valid), .f_call(f_call), .f_ret(f_ret),
      .f_pc0(f_pc0), .f_pc1(f_pc1), .c_call(c_call), .c_ret(c_ret), .flush(flush),
      .f_stall(f_stall), .push(push), .pop(pop), .pc(pc), .top_reset(top_reset),
      .top_commit(top_commit), .spec_depth(spec_depth),
`ifdef RAS_CTRL_STAT_EN
      .stat_flush(stat_flush), .stat_stall(stat_stall), .stat_underflow(stat_underflow),
`endif
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  v, c, r;
      logic [31:0] p0, p1;
      logic [1:0]  cc, cr;
      logic        fl;
   } vin_t;

   typedef struct {
      logic        push, pop, stall, tr, uf;
      logic [31:0] pc;
      int          tc, dep;
   } exp_t;

   typedef struct {
      vin_t in;
      exp_t ex;
   } vec_t;

   typedef struct {
      bit          c, r;
      logic [31:0] pc;
   } op_t;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: ops waiting for the single port, a recovery bubble flag, plain integer counters.
   op_t m_wait[$];
   bit  m_recov;
   int  m_depth, m_cdepth, m_ctop;

   function automatic vin_t vi(logic [1:0] v, c, r, logic [31:0] p0, p1,
                               logic [1:0] cc, cr, logic fl);
      vin_t x;
      x.v = v; x.c = c; x.r = r; x.p0 = p0; x.p1 = p1; x.cc = cc; x.cr = cr; x.fl = fl;
      return x;
   endfunction

   function automatic exp_t ve(logic pu, po, st, tr, uf, logic [31:0] p, int tc, int dep);
      exp_t e;
      e.push = pu; e.pop = po; e.stall = st; e.tr = tr; e.uf = uf; e.pc = p; e.tc = tc; e.dep = dep;
      return e;
   endfunction

   task automatic model_reset();
      m_wait.delete();
      m_recov = 0; m_depth = 0; m_cdepth = 0; m_ctop = 0;
   endtask

   task automatic model_step(input vin_t x, output exp_t e);
      op_t fetched[$];
      op_t o;
      bit  have;
      e = ve(0, 0, 0, 0, 0, 0, 0, m_depth);
      for (int i = 0; i < 2; i++) begin
         if (x.v[i] && (x.c[i] || x.r[i])) begin
            o.c = x.c[i]; o.r = x.r[i]; o.pc = (i == 0) ? x.p0 : x.p1;
            fetched.push_back(o);
         end
      end
      for (int i = 0; i < 2; i++) begin
         if (x.cc[i] && !x.cr[i]) begin
            m_ctop = (m_ctop + 1) % DMAX;
            if (m_cdepth < DMAX) m_cdepth++;
         end else if (x.cr[i] && !x.cc[i]) begin
            m_ctop = (m_ctop + DMAX - 1) % DMAX;
            if (m_cdepth > 0) m_cdepth--;
         end
      end
      e.tc = m_ctop;
      have = 0;
      if (x.fl) begin
         e.tr = 1; e.stall = m_recov;
         m_wait.delete();
         m_recov = 1;
         m_depth = m_cdepth;
      end else if (m_recov) begin
         e.stall = 1; m_recov = 0;
      end else if (m_wait.size() > 0) begin
         o = m_wait.pop_front(); have = 1;
      end else if (fetched.size() > 0) begin
         o = fetched.pop_front(); have = 1;
         if (fetched.size() > 0) begin
            e.stall = 1;
            m_wait.push_back(fetched.pop_front());
         end
      end
      if (have) begin
         if (o.r && !o.c && m_depth == 0) e.uf = 1;
         else begin
            e.push = o.c; e.pop = o.r;
            if (o.c) e.pc = o.pc + 32'd8;
            if (o.c && !o.r && m_depth < DMAX) m_depth++;
            else if (o.r && !o.c) m_depth--;
         end
      end
   endtask

   task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(vin_t x);
      f_valid = x.v; f_call = x.c; f_ret = x.r; f_pc0 = x.p0; f_pc1 = x.p1;
      c_call = x.cc; c_ret = x.cr; flush = x.fl;
   endtask

   task automatic check_all(string tag, int idx, exp_t e);
      chk({tag, ".push"}, idx, 32'(push), 32'(e.push));
      chk({tag, ".pop"}, idx, 32'(pop), 32'(e.pop));
      chk({tag, ".pc"}, idx, pc, e.pc);
      chk({tag, ".f_stall"}, idx, 32'(f_stall), 32'(e.stall));
      chk({tag, ".top_reset"}, idx, 32'(top_reset), 32'(e.tr));
      chk({tag, ".underflow"}, idx, 32'(underflow), 32'(e.uf));
      chk({tag, ".top_commit"}, idx, 32'(top_commit), e.tc);
      chk({tag, ".spec_depth"}, idx, 32'(spec_depth), e.dep);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      drive(vi(2'b11, 2'b11, 2'b00, 32'h40, 32'h44, 2'b11, 2'b00, 1'b1));
      @(negedge clk);
      #1;
      check_all("reset", 0, ve(0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      reset = 1'b0;
      drive(vi(0, 0, 0, 0, 0, 0, 0, 0));
      model_reset();
   endtask

   task automatic model_cycle(string tag, int idx, vin_t x);
      exp_t e;
      if (idx != 0 || tag != "") @(negedge clk);
      drive(x);
      model_step(x, e);
      #1;
      check_all(tag, idx, e);
   endtask

   vec_t tbl[16];

   initial begin
      vin_t x;
      reset = 1'b1;
      drive(vi(0, 0, 0, 0, 0, 0, 0, 0));

      // Directed sequence from reset; expected values worked out by hand.
      tbl[0]  = '{vi(2'b01, 2'b01, 2'b00, 32'h1000, 32'h0, 2'b00, 2'b00, 0), ve(1, 0, 0, 0, 0, 32'h1008, 0, 0)};
      tbl[1]  = '{vi(2'b11, 2'b11, 2'b00, 32'h2000, 32'h2004, 2'b00, 2'b00, 0), ve(1, 0, 1, 0, 0, 32'h2008, 0, 1)};
      tbl[2]  = '{vi(2'b01, 2'b00, 2'b01, 32'h5000, 32'h0, 2'b00, 2'b00, 0), ve(1, 0, 0, 0, 0, 32'h200C, 0, 2)};
      tbl[3]  = '{vi(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 0), ve(0, 0, 0, 0, 0, 0, 0, 3)};
      tbl[4]  = '{vi(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1), ve(0, 0, 0, 1, 0, 0, 0, 3)};
      tbl[5]  = '{vi(2'b01, 2'b01, 2'b00, 32'h6000, 32'h0, 2'b00, 2'b00, 0), ve(0, 0, 1, 0, 0, 0, 0, 0)};
      tbl[6]  = '{vi(2'b01, 2'b00, 2'b01, 32'h0, 32'h0, 2'b00, 2'b00, 0), ve(0, 0, 0, 0, 1, 0, 0, 0)};
      tbl[7]  = '{vi(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 0), ve(0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[8]  = '{vi(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 2'b00, 0), ve(0, 0, 0, 0, 0, 0, 2, 0)};
      tbl[9]  = '{vi(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'b01, 2'b00, 1), ve(0, 0, 0, 1, 0, 0, 3, 0)};
      tbl[10] = '{vi(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 0), ve(0, 0, 1, 0, 0, 0, 3, 3)};
      tbl[11] = '{vi(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 0), ve(0, 0, 0, 0, 0, 0, 3, 3)};
      tbl[12] = '{vi(2'b11, 2'b11, 2'b00, 32'h3000, 32'h3004, 2'b00, 2'b00, 0), ve(1, 0, 1, 0, 0, 32'h3008, 3, 3)};
      tbl[13] = '{vi(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1), ve(0, 0, 0, 1, 0, 0, 3, 4)};
      tbl[14] = '{vi(2'b01, 2'b01, 2'b00, 32'h7000, 32'h0, 2'b00, 2'b00, 0), ve(0, 0, 1, 0, 0, 0, 3, 3)};
      tbl[15] = '{vi(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 0), ve(0, 0, 0, 0, 0, 0, 3, 3)};

      do_reset();
      for (int i = 0; i < 16; i++) begin
         if (i != 0) @(negedge clk);
         drive(tbl[i].in);
         #1;
         check_all("tbl", i, tbl[i].ex);
      end

      // Nine pushes with matching commits: depth saturates, committed top wraps to 1.
      do_reset();
      for (int i = 0; i < 9; i++)
         model_cycle("wrap", i + 1, vi(2'b01, 2'b01, 2'b00, 32'h100 * i, 32'h0, 2'b01, 2'b00, 0));
      @(negedge clk);
      drive(vi(0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      chk("wrap.spec_depth_sat", 0, 32'(spec_depth), 32'd8);
      chk("wrap.top_commit", 0, 32'(top_commit), 32'd1);

      // Random traffic against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         x.v  = 2'($urandom);
         x.c  = 2'($urandom);
         x.r  = 2'($urandom);
         x.p0 = $urandom;
         x.p1 = $urandom;
         x.cc = 2'($urandom);
         x.cr = 2'($urandom) & ~x.cc;
         x.fl = ($urandom_range(15) == 0);
         model_cycle("rnd", n + 1, x);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
